// File: rtl/parking_input_frontend.sv
// -----------------------------------------------------------------------------
// parking_input_frontend
//
// Input conditioning and password capture ahead of the parking controller.
// The raw entrance/exit sensors are optionally synchronised, then debounced.
// A two-digit password is assembled from keypad strobes and held stable on
// password_1/password_2 until a clear, a timeout or reset.
//
// Build option:
//   PARKING_FRONTEND_SYNC_EN  defined   -> two-flop synchroniser on each raw
//                                          sensor before the debounce
//                             undefined -> raw sensors feed the debounce
//                                          directly (synchronous benches only)
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed before a sensor output changes (1..255)
//   TIMEOUT_CYCLES   cycles allowed between first and second digit (2..65535)
//
// Ports:
//   clk              single clock, rising edge
//   reset_n          asynchronous active-low reset
//   raw_entrance     raw entrance sensor (asynchronous)
//   raw_exit         raw exit sensor (asynchronous)
//   key_data[1:0]    keypad digit, valid with key_valid
//   key_valid        single-cycle digit strobe
//   key_clear        single-cycle clear strobe
//   sensor_entrance  debounced entrance sensor
//   sensor_exit      debounced exit sensor
//   password_1[1:0]  first captured digit
//   password_2[1:0]  second captured digit
//   pass_ready       both digits captured
//   entry_err        one-cycle error pulse (timeout or extra digit)
//
// Capture FSM:
//   state     | meaning
//   EMPTY     | no digit captured, both digits 00
//   ONE_DIGIT | first digit held, timeout counter running
//   FULL      | both digits held, pass_ready high
// -----------------------------------------------------------------------------
module parking_input_frontend #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       raw_entrance,
    input  logic       raw_exit,
    input  logic [1:0] key_data,
    input  logic       key_valid,
    input  logic       key_clear,
    output logic       sensor_entrance,
    output logic       sensor_exit,
    output logic [1:0] password_1,
    output logic [1:0] password_2,
    output logic       pass_ready,
    output logic       entry_err
);

    localparam logic [7:0]  DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        ONE_DIGIT = 2'd1,
        FULL      = 2'd2
    } state_t;

    // index 0 = entrance, index 1 = exit
    logic [1:0] cond;
    logic [1:0] deb_q;
    logic [7:0] deb_cnt [2];

    // ------------------------------------------------------------------
    // Sensor conditioning
    // ------------------------------------------------------------------
`ifdef PARKING_FRONTEND_SYNC_EN
    logic [1:0] sync_1;
    logic [1:0] sync_2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 2'b00;
            sync_2 <= 2'b00;
        end else begin
            sync_1 <= {raw_exit, raw_entrance};
            sync_2 <= sync_1;
        end
    end

    assign cond = sync_2;
`else
    assign cond = {raw_exit, raw_entrance};
`endif

    // A change is accepted on the DEBOUNCE_CYCLES-th consecutive differing
    // sample; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_q <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (cond[i] != deb_q[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb_q[i]   <= cond[i];
                        deb_cnt[i] <= 8'd0;
                    end else if (deb_cnt[i] != 8'hFF) begin
                        deb_cnt[i] <= deb_cnt[i] + 8'd1;
                    end
                end else begin
                    deb_cnt[i] <= 8'd0;
                end
            end
        end
    end

    assign sensor_entrance = deb_q[0];
    assign sensor_exit     = deb_q[1];

    // ------------------------------------------------------------------
    // Password capture
    // ------------------------------------------------------------------
    state_t      state;
    state_t      state_next;
    logic [15:0] to_cnt;
    logic [15:0] to_cnt_next;
    logic [1:0]  pw1_next;
    logic [1:0]  pw2_next;
    logic        err_next;
    logic        exit_prev;
    logic        clear_evt;

    // A departing car (debounced exit rising) wipes any partial entry.
    assign clear_evt = key_clear | (sensor_exit & ~exit_prev);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            to_cnt     <= 16'd0;
            password_1 <= 2'b00;
            password_2 <= 2'b00;
            pass_ready <= 1'b0;
            entry_err  <= 1'b0;
            exit_prev  <= 1'b0;
        end else begin
            state      <= state_next;
            to_cnt     <= to_cnt_next;
            password_1 <= pw1_next;
            password_2 <= pw2_next;
            pass_ready <= (state_next == FULL);
            entry_err  <= err_next;
            exit_prev  <= sensor_exit;
        end
    end

    always_comb begin
        state_next  = state;
        to_cnt_next = 16'd0;
        pw1_next    = password_1;
        pw2_next    = password_2;
        err_next    = 1'b0;

        if (clear_evt) begin
            state_next = EMPTY;
            pw1_next   = 2'b00;
            pw2_next   = 2'b00;
        end else begin
            case (state)
                EMPTY: begin
                    if (key_valid) begin
                        pw1_next   = key_data;
                        state_next = ONE_DIGIT;
                    end
                end
                ONE_DIGIT: begin
                    // A digit on the final timeout cycle still wins.
                    if (key_valid) begin
                        pw2_next   = key_data;
                        state_next = FULL;
                    end else if (to_cnt == TO_LAST) begin
                        state_next = EMPTY;
                        pw1_next   = 2'b00;
                        pw2_next   = 2'b00;
                        err_next   = 1'b1;
                    end else begin
                        to_cnt_next = to_cnt + 16'd1;
                    end
                end
                FULL: begin
                    if (key_valid) begin
                        err_next = 1'b1;
                    end
                end
                default: begin
                    state_next = EMPTY;
                    pw1_next   = 2'b00;
                    pw2_next   = 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parking_input_frontend.sv
module tb_parking_input_frontend;

    localparam int DEB = 4;
    localparam int TO  = 16;
`ifdef PARKING_FRONTEND_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk;
    logic       reset_n;
    logic       raw_entrance;
    logic       raw_exit;
    logic [1:0] key_data;
    logic       key_valid;
    logic       key_clear;
    logic       sensor_entrance;
    logic       sensor_exit;
    logic [1:0] password_1;
    logic [1:0] password_2;
    logic       pass_ready;
    logic       entry_err;

    parking_input_frontend #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .raw_entrance   (raw_entrance),
        .raw_exit       (raw_exit),
        .key_data       (key_data),
        .key_valid      (key_valid),
        .key_clear      (key_clear),
        .sensor_entrance(sensor_entrance),
        .sensor_exit    (sensor_exit),
        .password_1     (password_1),
        .password_2     (password_2),
        .pass_ready     (pass_ready),
        .entry_err      (entry_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    // Capture: number of digits held (0,1,2) plus the edge the first digit
    // was taken; timeout is "TO edges since the first digit, no key".
    int         m_digits;
    int         m_first_edge;
    int         edge_n;
    logic [1:0] m_pw1, m_pw2;
    logic       m_err;
    // Sensors: output follows a value once it has been seen for DEB
    // consecutive conditioned samples.
    logic       m_se, m_sx, m_sx_prev;
    logic       q_e[$];
    logic       q_x[$];
    logic       last_e, last_x;
    int         run_e, run_x;

    function automatic void model_reset();
        m_digits = 0; m_first_edge = 0; edge_n = 0;
        m_pw1 = 2'b00; m_pw2 = 2'b00; m_err = 1'b0;
        m_se = 1'b0; m_sx = 1'b0; m_sx_prev = 1'b0;
        q_e.delete(); q_x.delete();
        for (int i = 0; i < SYNC_LAT; i++) begin
            q_e.push_back(1'b0);
            q_x.push_back(1'b0);
        end
        last_e = 1'b0; last_x = 1'b0; run_e = 0; run_x = 0;
    endfunction

    task automatic tick();
        logic clr;
        logic c;
        @(posedge clk);
        edge_n++;
        clr   = key_clear || (m_sx && !m_sx_prev);
        m_err = 1'b0;
        if (clr) begin
            m_digits = 0; m_pw1 = 2'b00; m_pw2 = 2'b00;
        end else if (key_valid) begin
            if (m_digits == 0) begin
                m_pw1 = key_data; m_digits = 1; m_first_edge = edge_n;
            end else if (m_digits == 1) begin
                m_pw2 = key_data; m_digits = 2;
            end else begin
                m_err = 1'b1;
            end
        end else if (m_digits == 1 && (edge_n - m_first_edge) == TO) begin
            m_digits = 0; m_pw1 = 2'b00; m_pw2 = 2'b00; m_err = 1'b1;
        end
        m_sx_prev = m_sx;

        q_e.push_back(raw_entrance);
        c = q_e.pop_front();
        if (c === last_e) run_e++; else begin last_e = c; run_e = 1; end
        if (last_e !== m_se && run_e >= DEB) m_se = last_e;

        q_x.push_back(raw_exit);
        c = q_x.pop_front();
        if (c === last_x) run_x++; else begin last_x = c; run_x = 1; end
        if (last_x !== m_sx && run_x >= DEB) m_sx = last_x;
        #1;
    endtask

    task automatic apply_reset();
        raw_entrance = 1'b0; raw_exit = 1'b0;
        key_data = 2'b00; key_valid = 1'b0; key_clear = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #23;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic strobe_key(input logic [1:0] d);
        key_data = d; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        #1;
        n_tests++;
        if ({sensor_entrance, sensor_exit, pass_ready, entry_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got %b exp 0000", {sensor_entrance, sensor_exit, pass_ready, entry_err});
        end
        n_tests++;
        if ({password_1, password_2} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_passwords got %b exp 0000", {password_1, password_2});
        end
    endtask

    task automatic test_sensor_latency();
        int edges = 0;
        tick();
        raw_entrance = 1'b1;
        while (sensor_entrance !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        n_tests++;
        if (edges != SYNC_LAT + DEB) begin
            n_fail++;
            $display("FAIL entrance_latency got %0d edges exp %0d", edges, SYNC_LAT + DEB);
        end
        n_tests++;
        if (sensor_entrance !== m_se) begin
            n_fail++;
            $display("FAIL entrance_model got %b exp %b", sensor_entrance, m_se);
        end
        raw_entrance = 1'b0;
        edges = 0;
        while (sensor_entrance !== 1'b0 && edges < 40) begin
            tick();
            edges++;
        end
        n_tests++;
        if (edges != SYNC_LAT + DEB) begin
            n_fail++;
            $display("FAIL entrance_fall_latency got %0d edges exp %0d", edges, SYNC_LAT + DEB);
        end
    endtask

    task automatic test_glitch();
        logic saw_high = 1'b0;
        raw_entrance = 1'b1;
        repeat (DEB - 1) begin
            tick();
            saw_high |= sensor_entrance;
        end
        raw_entrance = 1'b0;
        repeat (12) begin
            tick();
            saw_high |= sensor_entrance;
        end
        n_tests++;
        if (saw_high !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_rejected got %b exp 0", saw_high);
        end
    endtask

    task automatic test_capture();
        strobe_key(2'b01);
        n_tests++;
        if ({password_1, pass_ready, entry_err} !== {2'b01, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL first_digit got pw1=%b rdy=%b err=%b exp 01 0 0", password_1, pass_ready, entry_err);
        end
        tick();
        strobe_key(2'b10);
        n_tests++;
        if ({password_1, password_2, pass_ready, entry_err} !== {2'b01, 2'b10, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL second_digit got %b/%b rdy=%b err=%b exp 01/10 1 0", password_1, password_2, pass_ready, entry_err);
        end
        repeat (3) tick();
        n_tests++;
        if ({password_1, password_2, pass_ready} !== {2'b01, 2'b10, 1'b1}) begin
            n_fail++;
            $display("FAIL full_hold got %b/%b rdy=%b exp 01/10 1", password_1, password_2, pass_ready);
        end
    endtask

    task automatic test_full_extra();
        strobe_key(2'b11);
        n_tests++;
        if ({entry_err, password_1, password_2, pass_ready} !== {1'b1, 2'b01, 2'b10, 1'b1}) begin
            n_fail++;
            $display("FAIL extra_digit got err=%b %b/%b rdy=%b exp 1 01/10 1", entry_err, password_1, password_2, pass_ready);
        end
        tick();
        n_tests++;
        if (entry_err !== 1'b0) begin
            n_fail++;
            $display("FAIL extra_err_width got %b exp 0", entry_err);
        end
    endtask

    task automatic test_exit_clear();
        int edges = 0;
        raw_exit = 1'b1;
        while (sensor_exit !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        n_tests++;
        if (sensor_exit !== 1'b1 || pass_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL exit_rise got sx=%b rdy=%b after %0d edges exp 1 1", sensor_exit, pass_ready, edges);
        end
        tick();
        n_tests++;
        if ({pass_ready, password_1, password_2} !== 5'b0) begin
            n_fail++;
            $display("FAIL exit_clear got rdy=%b %b/%b exp 0 00/00", pass_ready, password_1, password_2);
        end
        raw_exit = 1'b0;
        repeat (SYNC_LAT + DEB + 2) tick();
        key_clear = 1'b1;
        strobe_key(2'b11);
        key_clear = 1'b0;
        n_tests++;
        if ({password_1, pass_ready, entry_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL clear_and_key got pw1=%b rdy=%b err=%b exp 00 0 0", password_1, pass_ready, entry_err);
        end
        strobe_key(2'b10);
        n_tests++;
        if (password_1 !== 2'b10) begin
            n_fail++;
            $display("FAIL still_empty got pw1=%b exp 10", password_1);
        end
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
    endtask

    task automatic test_timeout();
        strobe_key(2'b01);
        for (int i = 1; i <= TO; i++) begin
            tick();
            n_tests++;
            if (i < TO) begin
                if (entry_err !== 1'b0 || password_1 !== 2'b01) begin
                    n_fail++;
                    $display("FAIL timeout_early cyc %0d got err=%b pw1=%b exp 0 01", i, entry_err, password_1);
                end
            end else if (entry_err !== 1'b1 || password_1 !== 2'b00 || password_2 !== 2'b00) begin
                n_fail++;
                $display("FAIL timeout_fire got err=%b %b/%b exp 1 00/00", entry_err, password_1, password_2);
            end
        end
        tick();
        n_tests++;
        if (entry_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_err_width got %b exp 0", entry_err);
        end
        strobe_key(2'b01);
        repeat (TO - 1) tick();
        strobe_key(2'b10);
        n_tests++;
        if ({entry_err, password_1, password_2, pass_ready} !== {1'b0, 2'b01, 2'b10, 1'b1}) begin
            n_fail++;
            $display("FAIL key_on_last_cycle got err=%b %b/%b rdy=%b exp 0 01/10 1", entry_err, password_1, password_2, pass_ready);
        end
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7) == 0) raw_entrance = ~raw_entrance;
            if ($urandom_range(9) == 0) raw_exit = ~raw_exit;
            key_data  = 2'($urandom_range(3));
            key_valid = ($urandom_range(3) == 0);
            key_clear = ($urandom_range(23) == 0);
            tick();
            n_tests++;
            if ({sensor_entrance, sensor_exit, password_1, password_2, pass_ready, entry_err} !==
                {m_se, m_sx, m_pw1, m_pw2, (m_digits == 2), m_err}) begin
                n_fail++;
                if (bad < 10)
                    $display("FAIL random cyc %0d got se=%b sx=%b %b/%b rdy=%b err=%b exp se=%b sx=%b %b/%b rdy=%b err=%b",
                             i, sensor_entrance, sensor_exit, password_1, password_2, pass_ready, entry_err,
                             m_se, m_sx, m_pw1, m_pw2, (m_digits == 2), m_err);
                bad++;
            end
        end
        key_valid = 1'b0;
        key_clear = 1'b0;
    endtask

    task automatic test_async_reset();
        raw_entrance = 1'b0; raw_exit = 1'b0;
        repeat (SYNC_LAT + DEB + 2) tick();
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        strobe_key(2'b11);
        raw_entrance = 1'b1;
        repeat (SYNC_LAT + 2) tick();
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({sensor_entrance, sensor_exit, password_1, password_2, pass_ready, entry_err} !== 8'b0) begin
            n_fail++;
            $display("FAIL async_reset got %b exp 00000000",
                     {sensor_entrance, sensor_exit, password_1, password_2, pass_ready, entry_err});
        end
        raw_entrance = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (SYNC_LAT + DEB + 2) tick();
        n_tests++;
        if ({sensor_entrance, password_1, pass_ready} !== 4'b0) begin
            n_fail++;
            $display("FAIL after_reset got se=%b pw1=%b rdy=%b exp 0 00 0", sensor_entrance, password_1, pass_ready);
        end
    endtask

    initial begin
        test_reset();
        test_sensor_latency();
        test_glitch();
        test_capture();
        test_full_extra();
        test_exit_clear();
        test_timeout();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
